// File: rtl/gobou_fc_sched.sv
// gobou_fc_sched: single fully-connected layer sequencer for the gobou
// MAC/bias/ReLU datapath. It walks output neurons in groups of CORE and, for
// each group, emits n_in accumulate cycles, one bias cycle, LAT drain cycles
// and CORE write cycles. Every output is registered. Each output register is
// loaded from the next-state and next-counter values, so its strobe lines up
// with the state that the FSM is entering.
module gobou_fc_sched #(
    parameter int CORE   = 16,
    parameter int LAT    = 3,
    parameter int DWIDTH = 16
) (
    input  logic                      i_clk,
    input  logic                      i_xrst,
    input  logic                      i_req,
    output logic                      o_ack,
    input  logic [DWIDTH-1:0]         i_n_in,
    input  logic [DWIDTH-1:0]         i_n_out,
    input  logic [DWIDTH-1:0]         i_in_base,
    input  logic [DWIDTH-1:0]         i_out_base,
    output logic [DWIDTH-1:0]         o_img_addr,
    output logic [DWIDTH-1:0]         o_net_addr,
    output logic                      o_mac_en,
    output logic                      o_mac_first,
    output logic                      o_bias_en,
    output logic                      o_out_we,
    output logic [$clog2(CORE)-1:0]   o_out_sel,
    output logic [DWIDTH-1:0]         o_out_addr
);

    localparam int SELW = $clog2(CORE);     // CORE >= 2 assumed
    localparam int LATW = $clog2(LAT) + 1;  // LAT >= 1 assumed

    // S_NULL is the single busy cycle spent on a zero-sized job.
    typedef enum logic [2:0] {
        S_IDLE, S_INPUT, S_BIAS, S_DRAIN, S_WRITE, S_NULL
    } state_t;

    state_t              r_state, w_nstate;
    logic [DWIDTH-1:0]   r_n_in, r_n_out, r_in_base, r_out_base;
    logic [DWIDTH-1:0]   r_i, w_ni;          // input index inside a group
    logic [DWIDTH-1:0]   r_w, w_nw;          // running weight/bias address
    logic [DWIDTH-1:0]   r_gbase, w_ngbase;  // g*CORE, first neuron of group
    logic [SELW-1:0]     r_k, w_nk;          // write lane
    logic [LATW-1:0]     r_drain, w_ndrain;
    logic                w_accept;
    logic [DWIDTH-1:0]   w_in_base;
    logic [DWIDTH:0]     w_lane;             // one bit wider so it cannot wrap

    // Next-state and next-counter logic.
    always_comb begin
        w_nstate = r_state;
        w_ni     = r_i;
        w_nw     = r_w;
        w_ngbase = r_gbase;
        w_nk     = r_k;
        w_ndrain = r_drain;
        w_accept = (r_state == S_IDLE) && i_req && (i_n_in != '0) && (i_n_out != '0);
        // The first INPUT address is formed before the config latch updates.
        w_in_base = w_accept ? i_in_base : r_in_base;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_nstate = S_INPUT;
                    w_ni     = '0;
                    w_nw     = '0;
                    w_ngbase = '0;
                end else if (i_req) begin
                    w_nstate = S_NULL;
                end
            end
            S_NULL: w_nstate = S_IDLE;
            S_INPUT: begin
                w_nw = r_w + DWIDTH'(1);
                if (r_i == r_n_in - DWIDTH'(1)) w_nstate = S_BIAS;
                else                            w_ni     = r_i + DWIDTH'(1);
            end
            S_BIAS: begin
                w_nw     = r_w + DWIDTH'(1);
                w_ndrain = '0;
                w_nstate = S_DRAIN;
            end
            S_DRAIN: begin
                if (r_drain == LATW'(LAT - 1)) begin
                    w_nstate = S_WRITE;
                    w_nk     = '0;
                end else begin
                    w_ndrain = r_drain + LATW'(1);
                end
            end
            S_WRITE: begin
                if (r_k == SELW'(CORE - 1)) begin
                    if ({1'b0, r_gbase} + (DWIDTH+1)'(CORE) >= {1'b0, r_n_out}) begin
                        w_nstate = S_IDLE;
                    end else begin
                        w_ngbase = r_gbase + DWIDTH'(CORE);
                        w_ni     = '0;
                        w_nstate = S_INPUT;
                    end
                end else begin
                    w_nk = r_k + SELW'(1);
                end
            end
            default: w_nstate = S_IDLE;
        endcase
        w_lane = {1'b0, w_ngbase} + (DWIDTH+1)'(w_nk);
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_xrst) r_state <= S_IDLE;
        else        r_state <= w_nstate;
    end

    // Counters, latched config, and registered strobes/addresses.
    always_ff @(posedge i_clk) begin
        if (i_xrst) begin
            r_n_in      <= '0;
            r_n_out     <= '0;
            r_in_base   <= '0;
            r_out_base  <= '0;
            r_i         <= '0;
            r_w         <= '0;
            r_gbase     <= '0;
            r_k         <= '0;
            r_drain     <= '0;
            o_ack       <= 1'b1;
            o_mac_en    <= 1'b0;
            o_mac_first <= 1'b0;
            o_bias_en   <= 1'b0;
            o_out_we    <= 1'b0;
            o_img_addr  <= '0;
            o_net_addr  <= '0;
            o_out_sel   <= '0;
            o_out_addr  <= '0;
        end else begin
            if (w_accept) begin
                r_n_in     <= i_n_in;
                r_n_out    <= i_n_out;
                r_in_base  <= i_in_base;
                r_out_base <= i_out_base;
            end
            r_i         <= w_ni;
            r_w         <= w_nw;
            r_gbase     <= w_ngbase;
            r_k         <= w_nk;
            r_drain     <= w_ndrain;
            o_ack       <= (w_nstate == S_IDLE);
            o_mac_en    <= (w_nstate == S_INPUT);
            o_mac_first <= (w_nstate == S_INPUT) && (w_ni == '0);
            o_bias_en   <= (w_nstate == S_BIAS);
            // Lanes beyond n_out in the final group are masked.
            o_out_we    <= (w_nstate == S_WRITE) && (w_lane < {1'b0, r_n_out});
            // Addresses hold whenever their strobe is idle.
            if (w_nstate == S_INPUT) begin
                o_img_addr <= w_in_base + w_ni;
                o_net_addr <= w_nw;
            end
            if (w_nstate == S_BIAS) o_net_addr <= w_nw;
            if (w_nstate == S_WRITE) begin
                o_out_sel  <= w_nk;
                o_out_addr <= r_out_base + w_ngbase + DWIDTH'(w_nk);
            end
        end
    end

endmodule

// File: doc/gobou_fc_sched.md
# gobou_fc_sched

Sequencer for one fully-connected layer on the gobou MAC/bias/ReLU datapath. It accepts a layer job through a `req`/`ack` handshake and latches the layer dimensions and base addresses. It then walks the output neurons in groups of `CORE`, generating image-memory and weight-memory addresses plus MAC/bias/write strobes. It sits between the top-level job interface and the per-stage control pipeline, replacing hand-sequenced control for a single layer.

## Interface
- `CORE`, 16: parallel MAC lanes, i.e. output neurons per group.
- `LAT`, 3: cycles from the bias strobe to the first valid ReLU output.
- `DWIDTH`, 16: width of counts and addresses.
- `clk`  in  1  clock; all logic is on the rising edge.
- `xrst`  in  1  reset, synchronous, active-high.
- `req`  in  1  start pulse; sampled only while idle.
- `ack`  out  1  1 = idle/done, 0 = busy.
- `n_in`  in  DWIDTH  input count; latched on accepted `req`.
- `n_out`  in  DWIDTH  output count; latched on accepted `req`.
- `in_base`, `out_base`  in  DWIDTH  image-memory base addresses for input and output; latched on accepted `req`.
- `img_addr`  out  DWIDTH  image read address.
- `net_addr`  out  DWIDTH  weight/bias read address.
- `mac_en`  out  1  accumulate this cycle.
- `mac_first`  out  1  first accumulate of a group (clears the accumulators).
- `bias_en`  out  1  add bias this cycle.
- `out_we`  out  1  write one output word.
- `out_sel`  out  log2(CORE)  lane to write.
- `out_addr`  out  DWIDTH  output write address.

## Operation
- FSM states: IDLE, INPUT, BIAS, DRAIN, WRITE.
- IDLE: `ack`=1.
  - `req`=1 with `n_in`>0 and `n_out`>0: latch all config, set group g=0, i=0, go to INPUT.
  - `req`=1 with `n_in`==0 or `n_out`==0: go through one busy cycle (`ack`=0, no strobes), then return to IDLE.
- INPUT, lasting `n_in` cycles:
  - `mac_en`=1; `mac_first`=1 only when i==0.
  - `img_addr`=in_base+i; `net_addr`=w, where w is a running counter cleared at job start.
  - i and w increment each cycle; after i==n_in-1, go to BIAS.
- BIAS, 1 cycle: `bias_en`=1, `net_addr`=w, w increments. Weight layout per group is n_in weights followed by 1 bias, so group g starts at g·(n_in+1).
- DRAIN: wait exactly `LAT` cycles with all strobes 0.
- WRITE, lasting `CORE` cycles, k=0..CORE-1:
  - `out_sel`=k; `out_addr`=out_base+g·CORE+k.
  - `out_we`=1 only if g·CORE+k < n_out, so lanes past the end of the last group are masked.
  - After k==CORE-1: if (g+1)·CORE ≥ n_out go to IDLE, else g++, i=0, go to INPUT.
- Number of groups = ceil(n_out/CORE).
- `req` while busy is ignored and not queued.
- Address arithmetic wraps modulo 2^DWIDTH; there is no overflow detection.
- All strobes and addresses are registered outputs.
- Addresses hold their last value when the corresponding strobe is 0; they are don't-care for the bench.

## Timing
- Reset values: `ack`=1; `mac_en`, `mac_first`, `bias_en`, `out_we`=0; `img_addr`, `net_addr`, `out_addr`, `out_sel`=0; state IDLE.
- `xrst` asserted mid-job aborts the job immediately. On the next edge all outputs take their reset values and no further strobes are issued.
- Accepted `req` at edge t: `ack`=0 and the first `mac_en`/`mac_first` are visible in cycle t+1.
- Cycles per group = n_in + 1 + LAT + CORE.
- Busy cycles = groups · (n_in+1+LAT+CORE). `ack` returns to 1 in the cycle after the last WRITE cycle.
- `req` held high across job completion starts a new job on the first IDLE cycle. `ack` is then high for exactly 1 cycle.
- A degenerate job (zero count) holds `ack`=0 for exactly 1 cycle.

## Test plan
- Reset check: CORE=4, LAT=3. Assert `xrst` for 2 cycles → `ack`=1, all strobes 0, all addresses 0.
- Multi-group job: `n_in`=3, `n_out`=6, `in_base`=0x10, `out_base`=0x40.
  - `ack` is low for 22 cycles.
  - Group 0: `mac_en` with `img_addr` 0x10,0x11,0x12 and `net_addr` 0,1,2; bias at `net_addr` 3; 3 idle cycles; writes to 0x40..0x43.
  - Group 1: `net_addr` 4..7; writes only to 0x44 and 0x45, with `out_we`=0 for k=2,3.
- Single-lane layer: `n_in`=1, `n_out`=1 → `mac_first` and `mac_en` in the same cycle, then exactly 1 `out_we` at `out_base`. Busy for 9 cycles.
- Degenerate job: `n_out`=0 → `ack` low for 1 cycle, no strobes.
- Busy-time `req`: pulse `req` during INPUT → ignored; job length unchanged.
- Back-to-back jobs: hold `req` high → 2 jobs run with a single `ack`=1 cycle between them.
- Reset mid-job: assert `xrst` during WRITE → outputs take reset values next cycle; a later `req` runs a full, correct job.
